// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
package alu_pkg;

  localparam int SEL_W = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_NAND = 3'b110,
    OP_NOTA = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Full-adder carry: majority of the three inputs.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // True for the two ops that use and update the carry register.
  function automatic logic is_arith(input op_t o);
    return (o == OP_ADD) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_bit_cell.sv
// One-bit ALU cell: combinational result bit plus the carry flop that
// links successive bit positions of an add/subtract.
module serial_bit_cell
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ai,
  input  logic bi,
  input  op_t  op,
  input  logic init,
  input  logic load,
  input  logic en,
  output logic bit_val,
  output logic carry
);

  logic bi_eff_s;

  // Result bit for the current position; SUB adds the inverted B operand.
  always_comb begin
    bi_eff_s = bi;
    bit_val  = 1'b0;
    if (op == OP_SUB) begin
      bi_eff_s = ~bi;
    end else begin
      bi_eff_s = bi;
    end
    case (op)
      OP_ADD,
      OP_SUB:  bit_val = ai ^ bi_eff_s ^ carry;
      OP_AND:  bit_val = ai & bi;
      OP_OR:   bit_val = ai | bi;
      OP_XOR:  bit_val = ai ^ bi;
      OP_NOR:  bit_val = ~(ai | bi);
      OP_NAND: bit_val = ~(ai & bi);
      OP_NOTA: bit_val = ~ai;
      default: bit_val = 1'b0;
    endcase
  end

  // Carry flop: preset at operation start, ripples only for arithmetic ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry <= 1'b0;
    end else if (load) begin
      carry <= init;
    end else if (en && is_arith(op)) begin
      carry <= maj3(ai, bi_eff_s, carry);
    end else begin
      carry <= carry;
    end
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU controller: walks operands LSB first, drives the mux/demux
// select and data bit, and assembles the parallel result and flags.
module serial_alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [SEL_W-1:0] sl,
  output logic             bit_out,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

  state_t           state_r;
  op_t              op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic [SEL_W-1:0] idx_r;
  logic             busy_r;
  logic             done_r;
  logic             cout_r;
  logic             zero_r;

  logic             ai_s;
  logic             bi_s;
  logic             bi_eff_s;
  logic             bit_s;
  logic             carry_s;
  logic             accept_s;
  logic             init_s;
  logic             cout_nxt_s;
  logic [WIDTH-1:0] res_nxt_s;

  assign accept_s = (state_r == IDLE) && start;
  assign init_s   = (op == 3'b001);

  serial_bit_cell u_cell (
    .clk     (clk),
    .rst     (rst),
    .ai      (ai_s),
    .bi      (bi_s),
    .op      (op_r),
    .init    (init_s),
    .load    (accept_s),
    .en      (state_r == RUN),
    .bit_val (bit_s),
    .carry   (carry_s)
  );

  // Operand bit pick, next result vector and final carry for the current index.
  always_comb begin
    ai_s       = a_r[idx_r[IW-1:0]];
    bi_s       = b_r[idx_r[IW-1:0]];
    res_nxt_s  = result_r;
    res_nxt_s[idx_r[IW-1:0]] = bit_s;
    if (op_r == OP_SUB) begin
      bi_eff_s = ~bi_s;
    end else begin
      bi_eff_s = bi_s;
    end
    if (is_arith(op_r)) begin
      cout_nxt_s = maj3(ai_s, bi_eff_s, carry_s);
    end else begin
      cout_nxt_s = 1'b0;
    end
  end

  // Sequencer FSM with registered status, index, operands, result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      op_r     <= OP_ADD;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      idx_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cout_r   <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op_t'(op);
            result_r <= '0;
            idx_r    <= '0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end
        end
        RUN: begin
          result_r <= res_nxt_s;
          if (idx_r == LAST_IDX) begin
            idx_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            cout_r  <= cout_nxt_s;
            zero_r  <= (res_nxt_s == '0);
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + SEL_W'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          idx_r   <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // The data bit is only meaningful while a bit is being processed.
  assign bit_out = busy_r ? bit_s : 1'b0;
  assign busy    = busy_r;
  assign sl      = idx_r;
  assign done    = done_r;
  assign result  = result_r;
  assign cout    = cout_r;
  assign zero    = zero_r;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed self-checking bench for serial_alu_sequencer (WIDTH = 16).
module tb_serial_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic [3:0]  sl;
  logic        bit_out;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        zero;

  int tests;
  int fails;

  serial_alu_sequencer #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .sl      (sl),
    .bit_out (bit_out),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle. Accepts one operation, checks
  // the per-bit sequence, the done pulse, result/flags and that it stays idle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] exp_r,
                        input logic exp_c, input logic noise);
    logic ok;
    ok    = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!(busy === 1'b1 && sl === 4'(i) && bit_out === exp_r[i] && done === 1'b0)) ok = 1'b0;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a     = 16'($urandom);
        b     = 16'($urandom);
        op    = 3'($urandom);
      end
      @(posedge clk); #1;
    end
    check({tag, "_seq"},    {31'd0, ok}, 32'd1);
    check({tag, "_done"},   {31'd0, done}, 32'd1);
    check({tag, "_busy"},   {31'd0, busy}, 32'd0);
    check({tag, "_result"}, {16'd0, result}, {16'd0, exp_r});
    check({tag, "_cout"},   {31'd0, cout}, {31'd0, exp_c});
    check({tag, "_zero"},   {31'd0, zero}, {31'd0, (exp_r == 16'h0000)});
    if (noise) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_idle"}, {15'd0, busy, result}, {16'd0, exp_r});
  endtask

  initial begin
    int first_rise;
    int second_rise;
    logic prev_busy;
    logic saw_done;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = 16'h0000;
    b     = 16'h0000;
    #1;
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_outs",   {20'd0, sl, bit_out, done, cout, zero, 4'd0}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of an ADD abandons it.
    op = 3'b000; a = 16'h1234; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy",   {31'd0, busy}, 32'd0);
    check("midrst_sl",     {28'd0, sl}, 32'd0);
    check("midrst_result", {16'd0, result}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_nodone", {31'd0, saw_done}, 32'd0);
    run_op("add_after_rst", 3'b000, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0);

    run_op("add_ff",   3'b000, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
    run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("sub_neg",  3'b001, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_pos",  3'b001, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
    run_op("and",      3'b010, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0);
    run_op("or",       3'b011, 16'h0F0F, 16'h00F0, 16'h0FFF, 1'b0, 1'b0);
    run_op("xor",      3'b100, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0);
    run_op("nor",      3'b101, 16'h0F0F, 16'h00F0, 16'hF000, 1'b0, 1'b0);
    run_op("nand",     3'b110, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 1'b0);
    run_op("nota",     3'b111, 16'h1234, 16'hAAAA, 16'hEDCB, 1'b0, 1'b0);
    // Starts and operand changes during RUN/DONE must be ignored.
    run_op("noise_sub", 3'b001, 16'h0100, 16'h0001, 16'h00FF, 1'b1, 1'b1);

    // start held high: accepted operations are WIDTH+2 = 18 cycles apart.
    op = 3'b000; a = 16'h0003; b = 16'h0004; start = 1'b1;
    first_rise  = -1;
    second_rise = -1;
    prev_busy   = busy;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (busy === 1'b1 && prev_busy === 1'b0) begin
        if (first_rise < 0) first_rise = c;
        else if (second_rise < 0) second_rise = c;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    check("held_spacing", 32'(second_rise - first_rise), 32'd18);
    repeat (20) @(posedge clk);
    #1;
    check("held_result", {15'd0, busy, result}, {16'd0, 16'h0007});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
